// File: rtl/seg_scan_decoder.sv
// Recovers the four digits shown on a multiplexed, active-low 7-segment display
// by sampling the segment bus once per settled anode dwell.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 16,
  parameter int BLINK_WINDOW  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_data,
  input  logic [3:0] AN,
  output logic [3:0] digit_0,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic [3:0] digit_valid,
  output logic [3:0] blank,
  output logic [3:0] blink,
  output logic       frame_done,
  output logic       err
);

  logic [6:0] seg_s1, seg_s2;
  logic [3:0] an_s1, an_s2, an_prev;
  logic [7:0] dwell;
  logic       strobe;

  logic [3:0] digits [4];
  logic [6:0] quiet  [4];
  logic [3:0] seen;
  logic [3:0] lit_last;
  logic [1:0] last_pos;

  logic       pos_ok;
  logic [1:0] pos;
  logic       dec_ok;
  logic [3:0] dec_val;
  logic       seg_off;
  logic [6:0] quiet_inc;

  assign digit_0 = digits[0];
  assign digit_1 = digits[1];
  assign digit_2 = digits[2];
  assign digit_3 = digits[3];

  // A strobe is only honoured while AN is stable, so a change on the strobe cycle discards it.
  assign strobe = (an_s2 == an_prev) && (dwell == 8'(SETTLE_CYCLES - 1));

  always_comb begin
    pos_ok = 1'b1;
    pos    = 2'd0;
    case (an_s2)
      4'b0111: pos = 2'd0;
      4'b1011: pos = 2'd1;
      4'b1101: pos = 2'd2;
      4'b1110: pos = 2'd3;
      default: pos_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    seg_off = 1'b0;
    case (seg_s2)
      7'b0000001: dec_val = 4'd0;
      7'b1001111: dec_val = 4'd1;
      7'b0010010: dec_val = 4'd2;
      7'b0000110: dec_val = 4'd3;
      7'b1001100: dec_val = 4'd4;
      7'b0100100: dec_val = 4'd5;
      7'b0100000: dec_val = 4'd6;
      7'b0001111: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0000100: dec_val = 4'd9;
      7'b1111111: begin
        dec_ok  = 1'b0;
        seg_off = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    quiet_inc = quiet[pos];
    if (quiet[pos] != '1) quiet_inc = quiet[pos] + 7'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1      <= '1;
      seg_s2      <= '1;
      an_s1       <= '1;
      an_s2       <= '1;
      an_prev     <= '1;
      dwell       <= '0;
      digit_valid <= '0;
      blank       <= '0;
      blink       <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      seen        <= '0;
      lit_last    <= '0;
      last_pos    <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        digits[i] <= '0;
        quiet[i]  <= '0;
      end
    end else begin
      seg_s1  <= seg_data;
      seg_s2  <= seg_s1;
      an_s1   <= AN;
      an_s2   <= an_s1;
      an_prev <= an_s2;

      if (an_s2 != an_prev)  dwell <= '0;
      else if (dwell != '1)  dwell <= dwell + 8'd1;

      err        <= 1'b0;
      frame_done <= 1'b0;

      if (strobe && an_s2 != 4'b1111) begin
        if (!pos_ok) begin
          err <= 1'b1;
        end else begin
          last_pos   <= pos;
          frame_done <= (pos == 2'd3) && (last_pos == 2'd2);
          if (!dec_ok && !seg_off) begin
            err <= 1'b1;
          end else begin
            if (dec_ok) begin
              digits[pos]      <= dec_val;
              digit_valid[pos] <= 1'b1;
              blank[pos]       <= 1'b0;
            end else begin
              blank[pos] <= 1'b1;
            end
            seen[pos]     <= 1'b1;
            lit_last[pos] <= dec_ok;
            // The first sample after reset has no predecessor and never counts as a toggle.
            if (seen[pos] && (lit_last[pos] != dec_ok)) begin
              quiet[pos] <= '0;
              blink[pos] <= 1'b1;
            end else begin
              quiet[pos] <= quiet_inc;
              if (quiet_inc == 7'(BLINK_WINDOW - 1)) blink[pos] <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed and random scan sequences for seg_scan_decoder, checked against a
// per-sample behavioural model of the display.
module tb_seg_scan_decoder;

  localparam int SETTLE = 16;
  localparam int BW     = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_data;
  logic [3:0] AN;
  logic [3:0] digit_0, digit_1, digit_2, digit_3;
  logic [3:0] digit_valid, blank, blink;
  logic       frame_done, err;

  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .BLINK_WINDOW(BW)) dut (
    .clk(clk), .rst(rst), .seg_data(seg_data), .AN(AN),
    .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .digit_valid(digit_valid), .blank(blank), .blink(blink),
    .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  int frame_seen = 0;

  always @(negedge clk) begin
    if (err === 1'b1)        err_seen++;
    if (frame_done === 1'b1) frame_seen++;
  end

  // Reference model: one update per accepted display sample.
  int         m_dig [4];
  logic [3:0] m_valid, m_blank, m_blink, m_seen, m_lit;
  int         m_q [4];
  int         m_lastpos;
  int         m_err, m_frame;
  logic [3:0] prev_an;
  logic [6:0] pats [10];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_dig[i] = 0;
      m_q[i]   = 0;
    end
    m_valid = '0; m_blank = '0; m_blink = '0; m_seen = '0; m_lit = '0;
    m_lastpos = 0;
    prev_an = 4'b1111;
    err_seen = 0; frame_seen = 0; m_err = 0; m_frame = 0;
  endtask

  function automatic int an_pos(input logic [3:0] a);
    if (a == 4'b0111) return 0;
    if (a == 4'b1011) return 1;
    if (a == 4'b1101) return 2;
    if (a == 4'b1110) return 3;
    return -1;
  endfunction

  // Digit value, -2 for all-off, -1 for an unrecognised pattern.
  function automatic int seg_val(input logic [6:0] s);
    if (s == 7'b1111111) return -2;
    for (int i = 0; i < 10; i++) if (pats[i] == s) return i;
    return -1;
  endfunction

  task automatic model_sample(input logic [3:0] a, input logic [6:0] s);
    int  p, v;
    logic lit;
    if (a == 4'b1111) return;
    p = an_pos(a);
    if (p < 0) begin m_err++; return; end
    if (p == 3 && m_lastpos == 2) m_frame++;
    m_lastpos = p;
    v = seg_val(s);
    if (v == -1) begin m_err++; return; end
    lit = (v >= 0);
    if (lit) begin
      m_dig[p] = v; m_valid[p] = 1'b1; m_blank[p] = 1'b0;
    end else begin
      m_blank[p] = 1'b1;
    end
    if (m_seen[p] && (m_lit[p] != lit)) begin
      m_q[p] = 0; m_blink[p] = 1'b1;
    end else begin
      if (m_q[p] < 127) m_q[p]++;
      if (m_q[p] == BW - 1) m_blink[p] = 1'b0;
    end
    m_seen[p] = 1'b1;
    m_lit[p]  = lit;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".d0"}, 32'(digit_0), 32'(m_dig[0]));
    check({tag, ".d1"}, 32'(digit_1), 32'(m_dig[1]));
    check({tag, ".d2"}, 32'(digit_2), 32'(m_dig[2]));
    check({tag, ".d3"}, 32'(digit_3), 32'(m_dig[3]));
    check({tag, ".valid"}, 32'(digit_valid), 32'(m_valid));
    check({tag, ".blank"}, 32'(blank), 32'(m_blank));
    check({tag, ".blink"}, 32'(blink), 32'(m_blink));
    check({tag, ".errs"}, 32'(err_seen), 32'(m_err));
    check({tag, ".frames"}, 32'(frame_seen), 32'(m_frame));
  endtask

  // Hold one AN/seg pair; holds of 22+ cycles after an AN change yield one sample.
  task automatic step(input logic [3:0] a, input logic [6:0] s, input int hold);
    AN = a;
    seg_data = s;
    repeat (hold) @(negedge clk);
    if (hold >= 22 && a != prev_an) model_sample(a, s);
    prev_an = a;
  endtask

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int r, h;
    pats = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    rst = 1'b1; AN = 4'b1111; seg_data = 7'b1111111;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all("reset");

    // Full scan of 1,2,3,4, three rounds.
    for (int k = 0; k < 3; k++) begin
      step(4'b0111, pats[1], 100);
      step(4'b1011, pats[2], 100);
      step(4'b1101, pats[3], 100);
      step(4'b1110, pats[4], 100);
    end
    check_all("scan");
    check("scan.frame_count", 32'(frame_seen), 32'd3);

    // Digit 2 blinking: 25 lit, 25 blank, 25 lit, then 70 more lit.
    for (int k = 0; k < 75; k++) begin
      step(4'b1101, ((k / 25) % 2 == 1) ? 7'b1111111 : pats[5], 22);
      step(4'b1111, 7'b1111111, 4);
    end
    check_all("blink_on");
    check("blink_on.bit2", 32'(blink[2]), 32'd1);
    check("blink_on.digit2", 32'(digit_2), 32'd5);
    for (int k = 0; k < 70; k++) begin
      step(4'b1101, pats[5], 22);
      step(4'b1111, 7'b1111111, 4);
    end
    check_all("blink_off");
    check("blink_off.bit2", 32'(blink[2]), 32'd0);

    // Illegal anode code, then all-off held.
    step(4'b0011, pats[8], 100);
    check_all("bad_an");
    step(4'b1111, pats[8], 100);
    check_all("idle_an");

    // Illegal segment pattern on a legal position.
    step(4'b0111, 7'b1111110, 30);
    check_all("bad_seg");

    // Anode toggling faster than the settle time.
    for (int k = 0; k < 10; k++) step((k % 2 == 0) ? 4'b1011 : 4'b1101, pats[k], 10);
    check_all("fast_toggle");

    // Random scans.
    for (int k = 0; k < 40; k++) begin
      do begin
        r = $urandom_range(0, 9);
        if (r < 6)      a = 4'b1111 ^ (4'b1000 >> $urandom_range(0, 3));
        else if (r < 8) a = 4'b1111;
        else            a = 4'($urandom);
      end while (a == prev_an);
      r = $urandom_range(0, 9);
      if (r < 7)      s = pats[$urandom_range(0, 9)];
      else if (r < 9) s = 7'b1111111;
      else            s = 7'($urandom);
      case ($urandom_range(0, 3))
        0: h = 8;
        1: h = 12;
        2: h = 24;
        default: h = 40;
      endcase
      step(a, s, h);
      check_all("random");
    end

    // Reset mid-dwell, then sample latency after reset release.
    step(4'b0111, pats[7], 30);
    check_all("pre_rst");
    AN = 4'b1011; seg_data = pats[2];
    repeat (11) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    check_all("mid_rst");
    rst = 1'b0;
    repeat (18) @(negedge clk);
    check("rst_latency.early", 32'(digit_valid[1]), 32'd0);
    @(negedge clk);
    check("rst_latency.on_time", 32'(digit_valid[1]), 32'd1);
    model_sample(4'b1011, pats[2]);
    prev_an = 4'b1011;
    check_all("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16; the number of clk cycles the synchronized AN must hold one value before its dwell is sampled (range 2..255).
REQ-002 SHALL have parameter BLINK_WINDOW, default 64; the number of per-digit samples without a lit/blank change before that digit's blink flag clears (range 2..127).
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port seg_data, input, 7 bits: active-low segments; bit6=a down to bit0=g.
REQ-006 SHALL have port AN, input, 4 bits: active-low anode enables; 0111=digit0, 1011=digit1, 1101=digit2, 1110=digit3.
REQ-007 SHALL have ports digit_0, digit_1, digit_2, digit_3, output, 4 bits each: last lit value decoded for that position.
REQ-008 SHALL have port digit_valid, output, 4 bits: bit n set once position n has decoded a lit digit.
REQ-009 SHALL have port blank, output, 4 bits: bit n = the most recent sample of position n was all-off (1111111).
REQ-010 SHALL have port blink, output, 4 bits: bit n = position n is toggling between lit and blank.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a digit3 sample directly follows a digit2 sample.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse on an illegal AN code or an illegal segment pattern.

Function
REQ-013 SHALL pass seg_data and AN each through a 2-flop synchronizer; all later logic uses only the synchronized values.
REQ-014 SHALL reset the dwell counter to 0 on any cycle where synchronized AN differs from its previous-cycle value, and otherwise increment it, saturating.
REQ-015 SHALL raise one sample strobe per dwell, on the cycle the counter equals SETTLE_CYCLES-1; no further strobe until AN changes again.
REQ-016 SHALL ignore AN=1111 (all off): no decode, no err, no effect on frame sequencing.
REQ-017 SHALL, at the strobe, pulse err for any AN value other than the four legal codes and 1111, and change no other state.
REQ-018 SHALL decode the segment patterns: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
REQ-019 SHALL, on a legal digit pattern at the strobe, write the value to digit_n, set digit_valid[n], and clear blank[n].
REQ-020 SHALL, on 1111111 at the strobe, set blank[n] and leave digit_n and digit_valid[n] unchanged.
REQ-021 SHALL, on any other pattern at the strobe, pulse err and leave all position-n state unchanged.
REQ-022 SHALL keep a per-position 7-bit quiet counter: it loads 0 and sets blink[n] when the lit/blank state differs from the previous sample of n; otherwise it increments; blink[n] clears when the counter reaches BLINK_WINDOW-1.
REQ-023 SHALL not treat the first sample of a position after reset as a toggle.
REQ-024 SHALL record the position index of the last legal-AN sample and pulse frame_done when the current strobe is digit3 and the recorded index is 2.
REQ-025 SHALL update all outputs on the clk edge after the strobe; total latency from an AN edge to an output change is 2+SETTLE_CYCLES+1 cycles.
REQ-026 SHALL, when AN changes on the same cycle the strobe would fire, restart the dwell and discard that strobe.

Reset
REQ-027 SHALL, while rst=1, clear: synchronizers to seg=1111111 and AN=1111, dwell and quiet counters to 0, digit_0..3 to 0, and digit_valid, blank, blink, frame_done, err to 0.
REQ-028 SHALL treat reset asserted mid-dwell as abandoning that dwell: no strobe fires until a full dwell completes after rst deasserts.

Verification
REQ-029 SHALL pass: scan 0111/1011/1101/1110 showing 1,2,3,4 with a 100-cycle dwell -> digit_0..3=1,2,3,4, digit_valid=1111, one frame_done pulse per cycle of the four codes, err never set.
REQ-030 SHALL pass: digit2 alternates 0100100 and 1111111 every 25 samples -> blink[2]=1 and digit_2 stays 5; after 70 lit-only samples -> blink[2]=0.
REQ-031 SHALL pass: AN=0011 held 100 cycles -> exactly one err pulse and outputs unchanged; AN=1111 held -> no err.
REQ-032 SHALL pass: AN=0111 with seg=1111110 -> one err pulse; digit_0 and digit_valid[0] unchanged.
REQ-033 SHALL pass: AN toggling every 10 cycles (SETTLE_CYCLES=16) -> no strobe, all outputs static.
REQ-034 SHALL pass: rst pulsed at dwell count 8 after digit_0=7 -> all outputs 0; the next sample fires 2+16 cycles after rst falls.
